// File: rtl/scope_chan_seq.sv
// ============================================================================
// Module   : scope_chan_seq
// Brief    : N-channel sample selector / sequencer (fixed, alternate, chop).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module scope_chan_seq #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int CHW   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic               in_valid,
    input  logic [1:0]         mode,
    input  logic [CHW-1:0]     sel,
    input  logic [NCH-1:0]     ch_enable,
    input  logic [7:0]         chop_len,
    input  logic               sweep_end,
    output logic [WIDTH-1:0]   out_data,
    output logic [CHW-1:0]     out_ch,
    output logic               out_valid
);

    localparam logic [1:0] c_MODE_ALT  = 2'b01;
    localparam logic [1:0] c_MODE_CHOP = 2'b10;

    logic [CHW-1:0]   r_cur_ch;
    logic [7:0]       r_cnt;
    logic [1:0]       r_mode_q;
    logic [WIDTH-1:0] r_out_data;
    logic [CHW-1:0]   r_out_ch;
    logic             r_out_valid;

    logic             w_fixed;
    logic [CHW-1:0]   w_fix_ch;
    logic             w_cur_en;
    logic             w_accept;
    logic             w_drop;
    logic [7:0]       w_chop_eff;
    logic             w_slot_done;
    logic [CHW-1:0]   w_next_ch;
    logic [CHW-1:0]   w_above_ch;
    logic [CHW-1:0]   w_low_ch;
    logic             w_has_above;
    logic             w_any;
    logic [WIDTH-1:0] w_sample;

    // Reserved mode 11 behaves exactly like fixed.
    assign w_fixed     = (mode != c_MODE_ALT) && (mode != c_MODE_CHOP);
    assign w_fix_ch    = (int'(sel) < NCH) ? sel : '0;
    assign w_cur_en    = ch_enable[r_cur_ch];
    assign w_accept    = in_valid && (w_fixed || w_cur_en);
    assign w_drop      = in_valid && !w_fixed && !w_cur_en;
    assign w_chop_eff  = (chop_len == 8'd0) ? 8'd1 : chop_len;
    assign w_slot_done = (r_cnt >= (w_chop_eff - 8'd1));

    // Descending scan: the last hit is the lowest enabled channel (wrap target)
    // and the lowest enabled channel strictly above the current one.
    always_comb begin
        w_next_ch   = r_cur_ch;
        w_above_ch  = '0;
        w_low_ch    = '0;
        w_has_above = 1'b0;
        w_any       = 1'b0;
        w_sample    = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (ch_enable[i]) begin
                w_any    = 1'b1;
                w_low_ch = CHW'(i);
                if (CHW'(i) > r_cur_ch) begin
                    w_has_above = 1'b1;
                    w_above_ch  = CHW'(i);
                end
            end
        end
        if (w_has_above) begin
            w_next_ch = w_above_ch;
        end else if (w_any) begin
            w_next_ch = w_low_ch;
        end
        for (int i = 0; i < NCH; i++) begin
            if (CHW'(i) == r_cur_ch) begin
                w_sample = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur_ch    <= '0;
            r_cnt       <= 8'd0;
            r_mode_q    <= 2'b00;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_mode_q    <= mode;
            r_out_valid <= w_accept;
            if (w_accept) begin
                r_out_data <= w_sample;
                r_out_ch   <= r_cur_ch;
            end

            if (w_fixed) begin
                r_cur_ch <= w_fix_ch;
                r_cnt    <= 8'd0;
            end else if (mode == c_MODE_ALT) begin
                r_cnt <= 8'd0;
                if (w_drop || sweep_end) begin
                    r_cur_ch <= w_next_ch;
                end
            end else begin
                if (w_drop) begin
                    r_cur_ch <= w_next_ch;
                    r_cnt    <= 8'd0;
                end else if (w_accept) begin
                    if (w_slot_done) begin
                        r_cur_ch <= w_next_ch;
                        r_cnt    <= 8'd0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
            end

            if (mode != r_mode_q) begin
                r_cnt <= 8'd0;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
    assign out_valid = r_out_valid;

endmodule

`default_nettype wire

// File: doc/scope_chan_seq.md
# scope_chan_seq

Parametrised N-channel sample selector and channel sequencer for the acquisition path. It takes one WIDTH-bit sample per channel on a common sample strobe and forwards one channel's sample, tagged with its channel number, to the trigger/capture logic. The channel choice is either fixed, advanced at each sweep end (alternate display), or advanced every chop_len samples (chop display). It replaces the plain 2:1 channel multiplexer in front of the capture buffer.

## Interface
- WIDTH, 8, sample width in bits
- NCH, 4, number of input channels (2..2**CHW)
- CHW, 2, channel index width

- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_data  in  NCH*WIDTH  channel i sample at bits [i*WIDTH +: WIDTH]
- in_valid  in  1  common sample strobe, one cycle per sample
- mode  in  2  00 fixed, 01 alternate, 10 chop, 11 reserved (behaves as fixed)
- sel  in  CHW  channel used in fixed mode
- ch_enable  in  NCH  channels taking part in alternate/chop sequencing
- chop_len  in  8  samples per chop slot; 0 treated as 1
- sweep_end  in  1  one-cycle pulse marking end of a sweep
- out_data  out  WIDTH  selected sample, registered
- out_ch  out  CHW  channel index of out_data
- out_valid  out  1  one-cycle strobe, out_data/out_ch valid

## Operation
- State: cur_ch (CHW bits), cnt (8 bits), mode_q (previous mode), and output registers.
- Fixed mode (00/11): cur_ch <= sel every cycle. If sel >= NCH, channel 0 is used. ch_enable is ignored.
- Capture: on an in_valid cycle where the sample is accepted, out_data <= in_data[cur_ch], out_ch <= cur_ch, and out_valid <= 1. Otherwise out_valid <= 0, and out_data/out_ch hold their values.
- Acceptance: fixed mode always accepts. Alternate/chop accept only if ch_enable[cur_ch]=1.
- Advance: cur_ch moves to the next enabled channel above cur_ch in ascending order, wrapping NCH-1 -> 0. If cur_ch is the only enabled channel, it stays.
  - If ch_enable == 0, cur_ch holds, nothing is accepted, and out_valid stays 0.
- Alternate (01): advance on sweep_end. cnt is held at 0.
- Chop (10):
  - An accepted sample with cnt >= chop_len_eff-1 advances the channel and sets cnt <= 0.
  - Any other accepted sample does cnt <= cnt+1.
  - The >= comparison makes a mid-slot shrink of chop_len take effect on the next sample.
- Disabled current channel (alternate/chop): an in_valid cycle drops the sample, advances immediately, and sets cnt <= 0.
- Mode change (mode != mode_q): cnt <= 0. cur_ch is kept, except that fixed mode loads sel.
- Simultaneous in_valid and sweep_end in alternate: the sample is taken from the old cur_ch, then the channel advances (the sample belongs to the ending sweep).
- sweep_end is ignored in fixed and chop modes.

## Timing
- Reset values: out_data=0, out_ch=0, out_valid=0, cur_ch=0, cnt=0, mode_q=00.
- Reset asserted mid-operation overrides everything on that edge. in_valid during reset is dropped.
- Latency: in_valid at cycle t gives out_valid at t+1, with data sampled at t.
- Channel switch: the sample on the triggering cycle uses the old channel. The next in_valid uses the new channel.
- sel change at cycle t applies to samples at t+1 onward.
- Back-to-back in_valid on every cycle is supported, so throughput is one sample per clock.
- No backpressure: out_valid is a strobe and the consumer must take it.

## Test plan
- Reset with in_valid=1 asserted during reset: all outputs 0. First in_valid after release (fixed, sel=0, ch0=0x11) -> out_data=0x11, out_ch=0, out_valid one cycle later.
- Fixed mode, channels 0x11/0x22/0x33/0x44, sel=2, then sel=3 at cycle t with in_valid at t and t+1 -> outputs 0x33 (ch2), then 0x44 (ch3).
- Chop, chop_len=3, ch_enable=1111, continuous in_valid -> out_ch sequence 0,0,0,1,1,1,2,2,2,3,3,3,0. Repeat with chop_len=0 -> 0,1,2,3,0.
- Chop, ch_enable=1010, chop_len=1, cur_ch=0 at start -> first sample dropped (out_valid=0), then out_ch 1,3,1,3. With ch_enable=0000 -> out_valid never asserted.
- Alternate, ch_enable=0110, sweep_end together with in_valid while cur_ch=1 -> that sample has out_ch=1. Next sample has out_ch=2, and the following sweep_end returns to 1.
- Chop, chop_len=8, cnt=5; switch mode to alternate and back to chop -> cnt restarts, and eight samples are taken on cur_ch before the advance.
